// File: rtl/sram_pingpong_matrix_pkg.sv
// Shared FFT sample type, read-mode and swap-FSM enums for the ping-pong matrix store.
package sram_pingpong_matrix_pkg;
  localparam int SFP_WIDTH = 16;
  typedef logic signed [SFP_WIDTH-1:0] sfp_t;

  typedef enum logic {RD_ROW = 1'b0, RD_COL = 1'b1} rd_mode_e;
  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} pp_state_e;
endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry read-return FIFO with a credit counter covering in-flight reads plus stored words,
// so an accepted request always has a slot waiting for it.
module sram_rd_fifo #(
  parameter int Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_dat_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] dat_o,
  output logic             credit_o
);
  logic [Width-1:0] mem_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       crd_q, crd_d;
  logic             pop;

  assign valid_o  = (cnt_q != 2'd0);
  assign pop      = valid_o && ready_i;
  assign dat_o    = mem_q[rptr_q];
  assign credit_o = (crd_q != 2'd2);

  always_comb begin
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop};
    crd_d = crd_q + {1'b0, req_i} - {1'b0, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
      crd_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= push_dat_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_d;
      crd_q <= crd_d;
    end
  end
endmodule

// File: rtl/sram_wrapper.sv
// Single-port synchronous SRAM macro model: one access per cycle, registered read data.
module sram_wrapper #(
  parameter int Width = 32,
  parameter int Depth = 128
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_pingpong_matrix.sv
// Ping-pong complex-sample matrix store: one half takes writes while the other serves row or
// column reads; a swap drains in-flight SRAM reads before flipping the halves.
module sram_pingpong_matrix
  import sram_pingpong_matrix_pkg::*;
#(
  parameter int NumLanes  = 4,
  parameter int NumGroups = 4,
  parameter int Depth     = 128,
  localparam int AddrWidth  = $clog2(Depth),
  localparam int GroupWidth = (NumGroups > 1) ? $clog2(NumGroups) : 1,
  localparam int MaxGL      = (NumGroups > NumLanes) ? NumGroups : NumLanes,
  localparam int SelWidth   = (MaxGL > 1) ? $clog2(MaxGL) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [GroupWidth-1:0] wr_group_i,
  input  logic [AddrWidth-1:0]  wr_addr_i,
  input  logic [NumLanes-1:0]   wr_lane_en_i,
  input  sfp_t [NumLanes-1:0]   wr_dr_i,
  input  sfp_t [NumLanes-1:0]   wr_di_i,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  input  logic                  rd_mode_i,
  input  logic [SelWidth-1:0]   rd_sel_i,
  input  logic [AddrWidth-1:0]  rd_addr_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output sfp_t [NumLanes-1:0]   rd_dr_o,
  output sfp_t [NumLanes-1:0]   rd_di_o,
  input  logic                  swap_i,
  output logic                  swap_done_o,
  output logic                  wr_half_o
);
  localparam int WordW = 2 * SFP_WIDTH;
  localparam int FifoW = 2 * NumLanes * SFP_WIDTH;

  pp_state_e             state_q, state_d;
  logic                  wr_half_q, wr_half_d;
  logic                  inflight_q;
  logic                  rd_half_q;
  rd_mode_e              mode_q;
  logic [SelWidth-1:0]   sel_q;
  logic                  wr_fire, rd_fire, credit;
  logic [WordW-1:0]      rdata [2][NumGroups][NumLanes];
  logic [WordW-1:0]      word;
  sfp_t [NumLanes-1:0]   mux_dr, mux_di;
  logic [FifoW-1:0]      fifo_dat;

  assign wr_fire   = wr_valid_i && wr_ready_o;
  assign rd_fire   = rd_valid_i && rd_ready_o;
  assign wr_half_o = wr_half_q;

  always_comb begin
    state_d     = state_q;
    wr_half_d   = wr_half_q;
    wr_ready_o  = 1'b0;
    rd_ready_o  = 1'b0;
    swap_done_o = 1'b0;
    case (state_q)
      ST_RUN: begin
        wr_ready_o = 1'b1;
        rd_ready_o = credit;
        if (swap_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Only the SRAM stage must be empty; the FIFO keeps old-half data and may drain later.
        if (!inflight_q) begin
          state_d     = ST_RUN;
          wr_half_d   = ~wr_half_q;
          swap_done_o = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      wr_half_q  <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_half_q  <= wr_half_d;
      inflight_q <= rd_fire;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_fire) begin
      rd_half_q <= ~wr_half_q;
      mode_q    <= rd_mode_e'(rd_mode_i);
      sel_q     <= rd_sel_i;
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    for (genvar g = 0; g < NumGroups; g++) begin : g_grp
      for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        logic wr_hit, rd_hit;
        assign wr_hit = wr_fire && (wr_half_q == 1'(h)) &&
                        (wr_group_i == GroupWidth'(g)) && wr_lane_en_i[l];
        assign rd_hit = rd_fire && (wr_half_q != 1'(h));

        sram_wrapper #(.Width(WordW), .Depth(Depth)) u_sram (
          .clk_i   (clk_i),
          .en_i    (wr_hit || rd_hit),
          .we_i    (wr_hit),
          .addr_i  (wr_hit ? wr_addr_i : rd_addr_i),
          .wdata_i ({wr_dr_i[l], wr_di_i[l]}),
          .rdata_o (rdata[h][g][l])
        );
      end
    end
  end

  // Column mode reverses group order so group 0 lands on the top output index.
  always_comb begin
    mux_dr = '0;
    mux_di = '0;
    word   = '0;
    for (int g = 0; g < NumGroups; g++) begin
      for (int l = 0; l < NumLanes; l++) begin
        word = rdata[rd_half_q][g][l];
        if (mode_q == RD_ROW && sel_q == SelWidth'(g)) begin
          mux_dr[l] = word[WordW-1:SFP_WIDTH];
          mux_di[l] = word[SFP_WIDTH-1:0];
        end
        if (mode_q == RD_COL && sel_q == SelWidth'(l) && (NumGroups - 1 - g) < NumLanes) begin
          mux_dr[NumGroups-1-g] = word[WordW-1:SFP_WIDTH];
          mux_di[NumGroups-1-g] = word[SFP_WIDTH-1:0];
        end
      end
    end
  end

  sram_rd_fifo #(.Width(FifoW)) u_rd_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_i      (rd_fire),
    .push_i     (inflight_q),
    .push_dat_i ({mux_dr, mux_di}),
    .valid_o    (rd_valid_o),
    .ready_i    (rd_ready_i),
    .dat_o      (fifo_dat),
    .credit_o   (credit)
  );

  assign {rd_dr_o, rd_di_o} = fifo_dat;
endmodule

// File: tb/tb_sram_pingpong_matrix.sv
// Directed bench for sram_pingpong_matrix: scoreboard of expected read words, popped on each
// read-data handshake, plus direct checks of handshakes, latency, swap and reset behaviour.
module tb_sram_pingpong_matrix;
  import sram_pingpong_matrix_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_i, wr_valid_i, wr_ready_o;
  logic [1:0] wr_group_i;
  logic [6:0] wr_addr_i;
  logic [3:0] wr_lane_en_i;
  sfp_t [3:0] wr_dr_i, wr_di_i;
  logic       rd_valid_i, rd_ready_o, rd_mode_i;
  logic [1:0] rd_sel_i;
  logic [6:0] rd_addr_i;
  logic       rd_valid_o, rd_ready_i;
  sfp_t [3:0] rd_dr_o, rd_di_o;
  logic       swap_i, swap_done_o, wr_half_o;

  sram_pingpong_matrix #(.NumLanes(4), .NumGroups(4), .Depth(128)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_group_i(wr_group_i),
    .wr_addr_i(wr_addr_i), .wr_lane_en_i(wr_lane_en_i), .wr_dr_i(wr_dr_i), .wr_di_i(wr_di_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_mode_i(rd_mode_i),
    .rd_sel_i(rd_sel_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_dr_o(rd_dr_o), .rd_di_o(rd_di_o),
    .swap_i(swap_i), .swap_done_o(swap_done_o), .wr_half_o(wr_half_o)
  );

  typedef struct packed {
    logic [63:0] dr;
    logic [63:0] di;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] l4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic exp_t mk(input logic [63:0] dr, input logic [63:0] di);
    exp_t e;
    e.dr = dr;
    e.di = di;
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    if (rd_valid_o && rd_ready_i && !rst_i) begin
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("rd_dr", 64'(rd_dr_o), e.dr);
        check("rd_di", 64'(rd_di_o), e.di);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] g, input logic [6:0] a, input logic [3:0] en,
                    input logic [63:0] dr, input logic [63:0] di);
    wr_valid_i = 1'b1; wr_group_i = g; wr_addr_i = a; wr_lane_en_i = en;
    wr_dr_i = dr; wr_di_i = di;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic do_swap();
    int lat;
    swap_i = 1'b1;
    tick();
    swap_i = 1'b0;
    lat = 1;
    while (!swap_done_o && lat < 8) begin
      tick();
      lat++;
    end
    check("swap_done_seen", 64'(swap_done_o), 64'd1);
    tick();
  endtask

  task automatic rd(input logic m, input logic [1:0] s, input logic [6:0] a,
                    input logic [63:0] edr, input logic [63:0] edi);
    int w;
    w = 0;
    rd_valid_i = 1'b1; rd_mode_i = m; rd_sel_i = s; rd_addr_i = a;
    while (!rd_ready_o && w < 8) begin
      tick();
      w++;
    end
    check("rd_ready_o", 64'(rd_ready_o), 64'd1);
    sb.push_back(mk(edr, edi));
    tick();
    rd_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] t1_dr, t1_di, mk_dr, mk_di;
    logic [1:0]  rs [4];
    logic [6:0]  ra [4];
    exp_t        bp_exp [4];
    int          acc, lat, vcnt;
    logic        acc_now;

    t1_dr = l4(16'h11, 16'h12, 16'h13, 16'h14);
    t1_di = l4(16'h111, 16'h112, 16'h113, 16'h114);
    mk_dr = l4(16'h00, 16'hFF, 16'h00, 16'hFF);
    mk_di = l4(16'h000, 16'h1FF, 16'h000, 16'h1FF);

    rst_i = 1'b1; wr_valid_i = 1'b0; wr_group_i = '0; wr_addr_i = '0; wr_lane_en_i = '0;
    wr_dr_i = '0; wr_di_i = '0; rd_valid_i = 1'b0; rd_mode_i = 1'b0; rd_sel_i = '0;
    rd_addr_i = '0; rd_ready_i = 1'b1; swap_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    check("rst_wr_half", 64'(wr_half_o), 64'd0);
    check("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("rst_swap_done", 64'(swap_done_o), 64'd0);
    check("rst_rd_dr", 64'(rd_dr_o), 64'd0);
    check("rst_rd_di", 64'(rd_di_o), 64'd0);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd1);
    check("rst_rd_ready", 64'(rd_ready_o), 64'd1);

    // Write then row read across a swap, with exact 2-cycle latency.
    wr(2'd1, 7'd5, 4'hF, t1_dr, t1_di);
    do_swap();
    check("wr_half_after_swap1", 64'(wr_half_o), 64'd1);
    rd(1'b0, 2'd1, 7'd5, t1_dr, t1_di);
    check("lat_cycle1_valid", 64'(rd_valid_o), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(rd_valid_o), 64'd1);
    tick();
    tick();

    // Column read: groups 0..3 lane 2 addr 7.
    for (int g = 0; g < 4; g++)
      wr(2'(g), 7'd7, 4'b0100, 64'(16'hA0 + g) << 32, 64'(16'h1A0 + g) << 32);
    do_swap();
    check("wr_half_after_swap2", 64'(wr_half_o), 64'd0);
    rd(1'b1, 2'd2, 7'd7, l4(16'hA3, 16'hA2, 16'hA1, 16'hA0),
       l4(16'h1A3, 16'h1A2, 16'h1A1, 16'h1A0));
    tick(); tick(); tick();

    // Lane masking.
    wr(2'd0, 7'd9, 4'hF, l4(16'hFF, 16'hFF, 16'hFF, 16'hFF),
       l4(16'h1FF, 16'h1FF, 16'h1FF, 16'h1FF));
    wr(2'd0, 7'd9, 4'b0101, 64'd0, 64'd0);
    do_swap();
    check("wr_half_after_swap3", 64'(wr_half_o), 64'd1);
    rd(1'b0, 2'd0, 7'd9, mk_dr, mk_di);
    tick(); tick(); tick();

    // Backpressure: consumer stalled, four requests offered back to back.
    rs[0] = 2'd1; ra[0] = 7'd5; bp_exp[0] = mk(t1_dr, t1_di);
    rs[1] = 2'd0; ra[1] = 7'd9; bp_exp[1] = mk(mk_dr, mk_di);
    rs[2] = 2'd1; ra[2] = 7'd5; bp_exp[2] = mk(t1_dr, t1_di);
    rs[3] = 2'd0; ra[3] = 7'd9; bp_exp[3] = mk(mk_dr, mk_di);
    rd_ready_i = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      rd_valid_i = 1'b1; rd_mode_i = 1'b0; rd_sel_i = rs[acc]; rd_addr_i = ra[acc];
      acc_now = rd_ready_o;
      if (acc_now) sb.push_back(bp_exp[acc]);
      if (i == 2) check("bp_head_early", 64'(rd_dr_o), t1_dr);
      tick();
      if (acc_now) acc++;
    end
    rd_valid_i = 1'b0;
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_valid_held", 64'(rd_valid_o), 64'd1);
    check("bp_head_held", 64'(rd_dr_o), t1_dr);
    check("bp_rd_ready_low", 64'(rd_ready_o), 64'd0);
    rd_ready_i = 1'b1;
    tick(); tick(); tick();
    check("bp_drained", 64'(sb.size()), 64'd0);
    rd(1'b0, rs[2], ra[2], bp_exp[2].dr, bp_exp[2].di);
    rd(1'b0, rs[3], ra[3], bp_exp[3].dr, bp_exp[3].di);
    tick(); tick(); tick(); tick();
    check("bp_rest_drained", 64'(sb.size()), 64'd0);

    // Swap in the same cycle as an accepted read: data comes from the old half.
    rd_valid_i = 1'b1; rd_mode_i = 1'b0; rd_sel_i = 2'd1; rd_addr_i = 7'd5; swap_i = 1'b1;
    check("swaprd_rd_ready", 64'(rd_ready_o), 64'd1);
    sb.push_back(mk(t1_dr, t1_di));
    tick();
    rd_valid_i = 1'b0; swap_i = 1'b0;
    check("drain_wr_ready", 64'(wr_ready_o), 64'd0);
    check("drain_rd_ready", 64'(rd_ready_o), 64'd0);
    lat = 1;
    while (!swap_done_o && lat < 8) begin
      tick();
      lat++;
    end
    check("swaprd_done_lat_1to2", 64'((lat >= 1 && lat <= 2) ? 1 : 0), 64'd1);
    tick();
    check("swaprd_wr_half", 64'(wr_half_o), 64'd0);
    check("swap_done_one_cycle", 64'(swap_done_o), 64'd0);
    tick(); tick();
    check("swaprd_drained", 64'(sb.size()), 64'd0);

    // Reset with two reads in flight: nothing stale may appear afterwards.
    do_swap();
    check("wr_half_before_rst", 64'(wr_half_o), 64'd1);
    rd_ready_i = 1'b0;
    rd_valid_i = 1'b1; rd_mode_i = 1'b0; rd_sel_i = 2'd1; rd_addr_i = 7'd5;
    tick();
    tick();
    rd_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    check("midrst_rd_valid", 64'(rd_valid_o), 64'd0);
    check("midrst_wr_half", 64'(wr_half_o), 64'd0);
    check("midrst_rd_dr", 64'(rd_dr_o), 64'd0);
    rst_i = 1'b0;
    rd_ready_i = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (rd_valid_o) vcnt++;
      tick();
    end
    check("midrst_no_stale", 64'(vcnt), 64'd0);
    check("midrst_rd_ready", 64'(rd_ready_o), 64'd1);
    check("midrst_wr_ready", 64'(wr_ready_o), 64'd1);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
